// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Holds the FSM state encoding and a digit-count helper used for sanity checks.
package bcd_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;

   // Decimal digits needed to represent 2^w-1
   function automatic int min_digits(input int w);
      longint v;
      int     d;
      v = (longint'(1) << w) - 1;
      d = 1;
      while (v >= 10) begin
         v = v / 10;
         d = d + 1;
      end
      return d;
   endfunction

endpackage

// File: rtl/bcd_add3_cell.sv
// Double-dabble digit correction: adds 3 to a BCD nibble holding 5..9 before the shift.
// A legal digit never exceeds 9, so the result (at most 12) always fits in 4 bits.
module bcd_add3_cell (
   input  logic [3:0] digit,
   output logic [3:0] adjusted
);

   always_comb begin
      adjusted = digit;
      if (digit >= 4'd5) adjusted = digit + 4'd3;
   end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one input bit per clock,
// with optional sign-magnitude handling and a sticky overflow flag.
module bin2bcd_seq
   import bcd_pkg::*;
#(
   parameter int BIN_W       = 8,
   parameter int DIGITS      = 3,
   parameter bit SIGNED_MODE = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [BIN_W-1:0]      bin_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [4*DIGITS-1:0]   bcd_o,
   output logic                  neg_o,
   output logic                  ovf_o
);

   localparam int CNT_W       = $clog2(BIN_W + 1);
   localparam int BCD_W       = 4 * DIGITS;
   localparam int FULL_DIGITS = min_digits(BIN_W);

   if (BIN_W < 2 || DIGITS < 1) begin : g_bad_params
      $error("bin2bcd_seq: BIN_W must be >= 2 and DIGITS >= 1");
   end

   bcd_state_t        state, state_nxt;
   logic [BIN_W-1:0]  shift_reg;
   logic [BCD_W-1:0]  work_bcd;
   logic [BCD_W-1:0]  adj_bcd;
   logic [CNT_W-1:0]  cnt;
   logic              neg_l;
   logic              ovf_l;
   logic              in_neg;

   for (genvar g = 0; g < DIGITS; g++) begin : g_cell
      bcd_add3_cell u_cell (
         .digit    (work_bcd[4*g +: 4]),
         .adjusted (adj_bcd[4*g +: 4])
      );
   end

   assign in_neg = SIGNED_MODE && bin_i[BIN_W-1];
   assign busy_o = (state != IDLE);

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start_i) state_nxt = SHIFT;
         SHIFT:   if (cnt == CNT_W'(1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         shift_reg <= '0;
         work_bcd  <= '0;
         cnt       <= '0;
         neg_l     <= 1'b0;
         ovf_l     <= 1'b0;
         done_o    <= 1'b0;
         bcd_o     <= '0;
         neg_o     <= 1'b0;
         ovf_o     <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  // Two's-complement negate; the most negative value maps to 2^(BIN_W-1) unsigned
                  shift_reg <= in_neg ? (~bin_i + BIN_W'(1)) : bin_i;
                  neg_l     <= in_neg;
                  work_bcd  <= '0;
                  ovf_l     <= 1'b0;
                  cnt       <= CNT_W'(BIN_W);
               end
            end
            SHIFT: begin
               {work_bcd, shift_reg} <= {adj_bcd[BCD_W-2:0], shift_reg, 1'b0};
               ovf_l                 <= ovf_l | adj_bcd[BCD_W-1];
               cnt                   <= cnt - CNT_W'(1);
            end
            DONE: begin
               bcd_o  <= work_bcd;
               neg_o  <= neg_l;
               ovf_o  <= ovf_l;
               done_o <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Overflow is only reachable when fewer digits are provisioned than 2^BIN_W-1 needs
   always_ff @(posedge clk) begin
      if (!rst && done_o) assert (!ovf_o || DIGITS < FULL_DIGITS);
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomised and directed self-check of bin2bcd_seq across several widths and modes,
// compared against an arithmetic (divide-by-ten) reference model.
module tb_bin2bcd_seq;

   localparam int NI = 7;
   localparam int BW [NI] = '{8, 8, 8, 4, 13, 16, 16};
   localparam int DG [NI] = '{3, 3, 2, 1, 4, 5, 4};
   localparam int SG [NI] = '{0, 1, 0, 0, 1, 0, 1};

   logic          clk = 1'b0;
   logic          rst;
   logic [NI-1:0] start;
   logic [15:0]   bin;
   wire  [NI-1:0] busy, done, neg, ovf;
   wire  [11:0]   bcd0, bcd1;
   wire  [7:0]    bcd2;
   wire  [3:0]    bcd3;
   wire  [15:0]   bcd4, bcd6;
   wire  [19:0]   bcd5;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bin2bcd_seq #(.BIN_W(8),  .DIGITS(3), .SIGNED_MODE(1'b0)) u0 (.clk(clk), .rst(rst), .start_i(start[0]),
      .bin_i(bin[7:0]),  .busy_o(busy[0]), .done_o(done[0]), .bcd_o(bcd0), .neg_o(neg[0]), .ovf_o(ovf[0]));
   bin2bcd_seq #(.BIN_W(8),  .DIGITS(3), .SIGNED_MODE(1'b1)) u1 (.clk(clk), .rst(rst), .start_i(start[1]),
      .bin_i(bin[7:0]),  .busy_o(busy[1]), .done_o(done[1]), .bcd_o(bcd1), .neg_o(neg[1]), .ovf_o(ovf[1]));
   bin2bcd_seq #(.BIN_W(8),  .DIGITS(2), .SIGNED_MODE(1'b0)) u2 (.clk(clk), .rst(rst), .start_i(start[2]),
      .bin_i(bin[7:0]),  .busy_o(busy[2]), .done_o(done[2]), .bcd_o(bcd2), .neg_o(neg[2]), .ovf_o(ovf[2]));
   bin2bcd_seq #(.BIN_W(4),  .DIGITS(1), .SIGNED_MODE(1'b0)) u3 (.clk(clk), .rst(rst), .start_i(start[3]),
      .bin_i(bin[3:0]),  .busy_o(busy[3]), .done_o(done[3]), .bcd_o(bcd3), .neg_o(neg[3]), .ovf_o(ovf[3]));
   bin2bcd_seq #(.BIN_W(13), .DIGITS(4), .SIGNED_MODE(1'b1)) u4 (.clk(clk), .rst(rst), .start_i(start[4]),
      .bin_i(bin[12:0]), .busy_o(busy[4]), .done_o(done[4]), .bcd_o(bcd4), .neg_o(neg[4]), .ovf_o(ovf[4]));
   bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED_MODE(1'b0)) u5 (.clk(clk), .rst(rst), .start_i(start[5]),
      .bin_i(bin[15:0]), .busy_o(busy[5]), .done_o(done[5]), .bcd_o(bcd5), .neg_o(neg[5]), .ovf_o(ovf[5]));
   bin2bcd_seq #(.BIN_W(16), .DIGITS(4), .SIGNED_MODE(1'b1)) u6 (.clk(clk), .rst(rst), .start_i(start[6]),
      .bin_i(bin[15:0]), .busy_o(busy[6]), .done_o(done[6]), .bcd_o(bcd6), .neg_o(neg[6]), .ovf_o(ovf[6]));

   function automatic logic [19:0] bcd_of(input int idx);
      case (idx)
         0:       return 20'(bcd0);
         1:       return 20'(bcd1);
         2:       return 20'(bcd2);
         3:       return 20'(bcd3);
         4:       return 20'(bcd4);
         5:       return bcd5;
         default: return 20'(bcd6);
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: decimal digits of the magnitude by repeated division
   task automatic ref_conv(input int idx, input logic [15:0] v,
                           output logic [19:0] bcd, output logic n, output logic o);
      int w, mag, lim;
      w   = BW[idx];
      mag = int'(v) & ((1 << w) - 1);
      n   = (SG[idx] != 0) && v[w-1];
      if (n) mag = (1 << w) - mag;
      lim = 1;
      for (int d = 0; d < DG[idx]; d++) lim = lim * 10;
      o   = (mag >= lim);
      mag = mag % lim;
      bcd = '0;
      for (int d = 0; d < DG[idx]; d++) begin
         bcd[4*d +: 4] = 4'(mag % 10);
         mag = mag / 10;
      end
   endtask

   task automatic conv_check(input int idx, input logic [15:0] val);
      logic [19:0] eb, prev;
      logic        en, eo;
      int          lat;
      bit          seen;
      ref_conv(idx, val, eb, en, eo);
      prev = bcd_of(idx);
      @(negedge clk);
      bin = val;
      start[idx] = 1'b1;
      @(posedge clk); #1;
      start[idx] = 1'b0;
      bin = 16'($urandom);
      chk($sformatf("u%0d.busy_on", idx), 32'(busy[idx]), 32'd1);
      lat = 0;
      seen = 1'b0;
      while (!seen && lat < 64) begin
         @(posedge clk); #1;
         lat++;
         seen = done[idx];
         if (lat == BW[idx] / 2)
            chk($sformatf("u%0d.hold", idx), 32'(bcd_of(idx)), 32'(prev));
      end
      chk($sformatf("u%0d.latency", idx), 32'(lat), 32'(BW[idx] + 1));
      chk($sformatf("u%0d.bcd(%0h)", idx, val), 32'(bcd_of(idx)), 32'(eb));
      chk($sformatf("u%0d.neg(%0h)", idx, val), 32'(neg[idx]), 32'(en));
      chk($sformatf("u%0d.ovf(%0h)", idx, val), 32'(ovf[idx]), 32'(eo));
      @(posedge clk); #1;
      chk($sformatf("u%0d.done_pulse", idx), 32'(done[idx]), 32'd0);
   endtask

   initial begin
      int  t;
      bit  seen;
      rst   = 1'b1;
      start = '0;
      bin   = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("u%0d.rst_bcd", i), 32'(bcd_of(i)), 32'd0);
         chk($sformatf("u%0d.rst_flags", i), 32'({busy[i], done[i], neg[i], ovf[i]}), 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;

      conv_check(0, 16'd255);
      chk("dir.255", 32'(bcd_of(0)), 32'h255);

      // start held high; operand changes during the conversion must not leak in
      @(negedge clk);
      bin = 16'd0;
      start[0] = 1'b1;
      @(posedge clk); #1;
      bin = 16'd99;
      t = 0;
      seen = 1'b0;
      while (!seen && t < 64) begin
         @(posedge clk); #1;
         t++;
         seen = done[0];
      end
      chk("b2b.lat1", 32'(t), 32'd9);
      chk("b2b.bcd1", 32'(bcd_of(0)), 32'h000);
      @(posedge clk); #1;
      start[0] = 1'b0;
      t = 1;
      seen = 1'b0;
      while (!seen && t < 64) begin
         @(posedge clk); #1;
         t++;
         seen = done[0];
      end
      chk("b2b.gap", 32'(t), 32'd10);
      chk("b2b.bcd2", 32'(bcd_of(0)), 32'h099);

      conv_check(1, 16'h0080);
      chk("dir.s80", 32'({neg[1], bcd_of(1)}), 32'h100128);
      conv_check(1, 16'h00FF);
      chk("dir.sFF", 32'({neg[1], bcd_of(1)}), 32'h100001);
      conv_check(2, 16'd255);
      chk("dir.ovf255", 32'({ovf[2], bcd_of(2)}), 32'h100055);
      conv_check(2, 16'd42);
      chk("dir.ovf42", 32'({ovf[2], bcd_of(2)}), 32'h000042);

      // abort a conversion with reset in its fourth shift cycle
      conv_check(0, 16'd255);
      @(negedge clk);
      bin = 16'd200;
      start[0] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort.bcd", 32'(bcd_of(0)), 32'd0);
      chk("abort.flags", 32'({busy[0], done[0], neg[0], ovf[0]}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (15) begin
         @(posedge clk); #1;
         if (done[0]) seen = 1'b1;
      end
      chk("abort.no_done", 32'(seen), 32'd0);
      conv_check(0, 16'd123);
      chk("dir.123", 32'(bcd_of(0)), 32'h123);

      for (int i = 0; i < NI; i++) begin
         conv_check(i, 16'd0);
         conv_check(i, 16'((1 << BW[i]) - 1));
         conv_check(i, 16'(1 << (BW[i] - 1)));
         for (int k = 0; k < 20; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            conv_check(i, 16'($urandom));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog expired");
   end

endmodule
